// File: rtl/awgn_bm_ctrl_if.sv
// Interface bundle for the Box-Muller sequencer.
// Groups the URNG pull port, the datapath operand/result port, the output sample stream
// and the status outputs.
//   master : controller view (drives urng_req, dp_*, out_valid/out_data, busy, sample_count)
//   slave  : environment view (drives en, urng_valid/urng_data, dp_g0/dp_g1, out_ready)
interface awgn_bm_ctrl_if #(
  parameter int U0_W = 32,
  parameter int U1_W = 16,
  parameter int G_W  = 16
);
  logic            en;
  logic            urng_req;
  logic            urng_valid;
  logic [31:0]     urng_data;
  logic [U0_W-1:0] dp_u0;
  logic [U1_W-1:0] dp_u1;
  logic            dp_start;
  logic [G_W-1:0]  dp_g0;
  logic [G_W-1:0]  dp_g1;
  logic            out_valid;
  logic            out_ready;
  logic [G_W-1:0]  out_data;
  logic            busy;
  logic [31:0]     sample_count;

  modport master (
    input  en, urng_valid, urng_data, dp_g0, dp_g1, out_ready,
    output urng_req, dp_u0, dp_u1, dp_start, out_valid, out_data, busy, sample_count
  );

  modport slave (
    output en, urng_valid, urng_data, dp_g0, dp_g1, out_ready,
    input  urng_req, dp_u0, dp_u1, dp_start, out_valid, out_data, busy, sample_count
  );
endinterface

// File: rtl/awgn_bm_ctrl.sv
// Box-Muller sequencer: pulls two URNG words (u0, u1), issues them to the log/sqrt/sincos
// datapath, waits out its fixed latency, captures g0/g1 and streams them g0 first.
// One pair in flight at a time.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous reset, active-low
//   bus    - awgn_bm_ctrl_if.master: en, URNG req/valid/data, dp_u0/dp_u1/dp_start,
//            dp_g0/dp_g1, out_valid/out_ready/out_data, busy, sample_count
// Build option: define SAMPLE_COUNT_EN to include the 32-bit transferred-sample counter;
// without it sample_count is tied to zero.
//
// state  | meaning
// IDLE   | parked, waiting for en
// FETCH0 | requesting URNG word for u0
// FETCH1 | requesting URNG word for u1
// ISSUE  | dp_start high, latency counter loaded
// WAIT   | counting down datapath latency, capture g0/g1 on the last cycle
// EMIT0  | presenting g0
// EMIT1  | presenting g1, then refetch or park depending on en
module awgn_bm_ctrl #(
  parameter int U0_W   = 32,
  parameter int U1_W   = 16,
  parameter int G_W    = 16,
  parameter int DP_LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  awgn_bm_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(DP_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, ISSUE, WAIT, EMIT0, EMIT1
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] lat_cnt;
  logic [G_W-1:0]  g1_q;
  logic [U0_W-1:0] dp_u0_q;
  logic [U1_W-1:0] dp_u1_q;
  logic [G_W-1:0]  out_data_q;
  logic            urng_req_q;
  logic            dp_start_q;
  logic            out_valid_q;
  logic            busy_q;

  // Outputs are registered alongside the state transition, so each one already
  // reflects the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      g1_q        <= '0;
      dp_u0_q     <= '0;
      dp_u1_q     <= '0;
      out_data_q  <= '0;
      urng_req_q  <= 1'b0;
      dp_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      dp_start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en) begin
            urng_req_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= FETCH0;
          end
        end
        FETCH0: begin
          if (bus.urng_valid) begin
            dp_u0_q <= bus.urng_data[U0_W-1:0];
            state   <= FETCH1;
          end
        end
        FETCH1: begin
          if (bus.urng_valid) begin
            dp_u1_q    <= bus.urng_data[U1_W-1:0];
            urng_req_q <= 1'b0;
            dp_start_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= CNT_W'(DP_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          // Last WAIT cycle is ISSUE + DP_LAT, when the datapath result is valid.
          if (lat_cnt == CNT_W'(1)) begin
            out_data_q  <= bus.dp_g0;
            g1_q        <= bus.dp_g1;
            out_valid_q <= 1'b1;
            lat_cnt     <= '0;
            state       <= EMIT0;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        EMIT0: begin
          if (bus.out_ready) begin
            out_data_q <= g1_q;
            state      <= EMIT1;
          end
        end
        EMIT1: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.en) begin
              urng_req_q <= 1'b1;
              state      <= FETCH0;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.urng_req  = urng_req_q;
  assign bus.dp_u0     = dp_u0_q;
  assign bus.dp_u1     = dp_u1_q;
  assign bus.dp_start  = dp_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

`ifdef SAMPLE_COUNT_EN
  logic [31:0] sample_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

  assign bus.sample_count = sample_cnt;
`else
  assign bus.sample_count = 32'd0;
`endif

endmodule

// File: tb/tb_awgn_bm_ctrl.sv
// Self-checking bench for awgn_bm_ctrl: random URNG/sink stalls, a DP_LAT-deep datapath
// model (g0 = u1+1, g1 = u1+2) and a per-cycle monitor holding the expected sample queue.
module tb_awgn_bm_ctrl;
  localparam int DP_LAT = 4;
  localparam int NW     = 1024;

  logic clk;
  logic rst_n;

  awgn_bm_ctrl_if #(.U0_W(32), .U1_W(16), .G_W(16)) bus ();

  awgn_bm_ctrl #(.U0_W(32), .U1_W(16), .G_W(16), .DP_LAT(DP_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // URNG word source shared by driver and model
  logic [31:0] words [NW];
  int cons_idx = 0;

  // stimulus knobs, written only by the main sequence
  int uv_pct        = 100;
  int rdy_pct       = 100;
  int f1_stall      = 0;
  bit force_rdy_off = 1'b0;

  // datapath model: DP_LAT-deep pipe, zero unless a start entered it
  logic [15:0] pipe0 [DP_LAT];
  logic [15:0] pipe1 [DP_LAT];

  always @(posedge clk) begin
    for (int i = DP_LAT - 1; i > 0; i--) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
    pipe0[0] <= bus.dp_start ? bus.dp_u1 + 16'd1 : 16'd0;
    pipe1[0] <= bus.dp_start ? bus.dp_u1 + 16'd2 : 16'd0;
  end

  assign bus.dp_g0 = pipe0[DP_LAT-1];
  assign bus.dp_g1 = pipe1[DP_LAT-1];

  // input driver, one cycle at a time just after the rising edge
  initial begin
    int f1_cyc;
    f1_cyc         = 0;
    bus.urng_valid = 1'b0;
    bus.urng_data  = 32'd0;
    bus.out_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.urng_req && (cons_idx % 2 == 1)) f1_cyc++;
      else f1_cyc = 0;
      bus.urng_data  = words[cons_idx % NW];
      bus.urng_valid = ($urandom_range(0, 99) < uv_pct) &&
                       !((cons_idx % 2 == 1) && (f1_cyc <= f1_stall));
      bus.out_ready  = !force_rdy_off && ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // reference model / monitor, evaluated on the falling edge
  logic [15:0] exp_q [$];
  logic [31:0] exp_u0 = 32'd0;
  logic [15:0] exp_u1 = 16'd0;
  logic [15:0] g;
  int  npairs = 0;
  int  xfer_cnt = 0;
  int  pair_base = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  bit  prev_valid = 1'b0;
  bit  prev_xfer = 1'b0;
  bit  prev_start = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_u0     = 32'd0;
      exp_u1     = 16'd0;
      npairs     = 0;
      xfer_cnt   = 0;
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
      prev_start = 1'b0;
      if (cons_idx % 2 == 1) cons_idx++;
      pair_base = cons_idx;
    end else begin
      check_val("dp_u0", bus.dp_u0, exp_u0);
      check_val("dp_u1", bus.dp_u1, exp_u1);
`ifdef SAMPLE_COUNT_EN
      check_val("sample_count", bus.sample_count, xfer_cnt);
`else
      check_val("sample_count", bus.sample_count, 0);
`endif
      if (bus.urng_req) check_val("req_exclusive", {bus.out_valid, bus.dp_start}, 2'b00);
      if (bus.urng_req || bus.dp_start || bus.out_valid) check_val("busy_active", bus.busy, 1);
      if (prev_start) check_val("start_pulse", bus.dp_start, 0);
      if (bus.dp_start) begin
        check_val("words_per_pair", cons_idx - pair_base, 2 * (npairs + 1));
        check_val("one_in_flight", exp_q.size(), 0);
        g = words[(cons_idx + NW - 1) % NW][15:0];
        exp_q.push_back(g + 16'd1);
        exp_q.push_back(g + 16'd2);
        npairs++;
        start_cyc = cyc;
      end
      if (prev_valid && !prev_xfer) check_val("valid_hold", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (!prev_valid) check_val("start_to_valid", cyc - start_cyc, DP_LAT + 1);
        if (exp_q.size() == 0) begin
          check_val("spurious_valid", bus.out_valid, 0);
        end else begin
          check_val("out_data", bus.out_data, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      prev_valid = bus.out_valid;
      prev_xfer  = bus.out_valid && bus.out_ready;
      prev_start = bus.dp_start;
      if (bus.urng_req && bus.urng_valid) begin
        if (cons_idx % 2 == 0) exp_u0 = words[cons_idx % NW];
        else exp_u1 = words[cons_idx % NW][15:0];
        cons_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (!bus.busy) break;
    end
    check_val(tag, bus.busy, 0);
    check_val({tag, "_req"}, bus.urng_req, 0);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (bus.out_valid) break;
    end
    check_val(tag, bus.out_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_urng_req"}, bus.urng_req, 0);
    check_val({tag, "_dp_start"}, bus.dp_start, 0);
    check_val({tag, "_out_valid"}, bus.out_valid, 0);
    check_val({tag, "_out_data"}, bus.out_data, 0);
    check_val({tag, "_dp_u0"}, bus.dp_u0, 0);
    check_val({tag, "_dp_u1"}, bus.dp_u1, 0);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_count"}, bus.sample_count, 0);
  endtask

  initial begin
    int n;
    int p0;
    int x0;
    int c0;
    bit seen;
`ifdef SAMPLE_COUNT_EN
    int exp_final = 200;
`else
    int exp_final = 0;
`endif
    for (int i = 0; i < NW; i++) words[i] = $urandom;
    words[0] = 32'h12345678;
    words[1] = 32'h0000ABCD;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    repeat (3) tick();
    check_reset_outputs("init_rst");
    rst_n = 1'b1;
    tick();

    // single pair, no stalls: first sample DP_LAT+4 edges after en is sampled
    bus.en = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 16 && !seen) begin
      @(posedge clk);
      n++;
      #1 bus.en = 1'b0;
      #1 if (bus.out_valid) seen = 1'b1;
    end
    check_val("first_valid_cycle", n, DP_LAT + 4);
    check_val("pair1_u0", bus.dp_u0, 32'h12345678);
    check_val("pair1_u1", bus.dp_u1, 16'hABCD);
    check_val("pair1_g0", bus.out_data, 16'hABCE);
    tick();
    check_val("pair1_g1", bus.out_data, 16'hABCF);
    wait_idle("pair1_idle", 20);

    // backpressure in EMIT0
    force_rdy_off = 1'b1;
    p0 = npairs;
    bus.en = 1'b1;
    wait_valid("bp_valid_seen", 40);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_valid", bus.out_valid, 1);
      check_val("bp_req", bus.urng_req, 0);
      check_val("bp_pairs", npairs, p0 + 1);
    end
    force_rdy_off = 1'b0;
    wait_idle("bp_idle", 20);

    // URNG stall in FETCH1
    f1_stall = 5;
    bus.en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.urng_req && (cons_idx % 2 == 1)) seen = 1'b1;
    end
    bus.en = 1'b0;
    check_val("stall_in_fetch1", seen, 1);
    c0 = cons_idx;
    p0 = npairs;
    for (int i = 0; i < 5; i++) begin
      check_val("stall_req", bus.urng_req, 1);
      check_val("stall_start", bus.dp_start, 0);
      check_val("stall_words", cons_idx, c0);
      tick();
    end
    for (int i = 0; i < 10 && npairs == p0; i++) tick();
    check_val("stall_release", npairs, p0 + 1);
    f1_stall = 0;
    wait_idle("stall_idle", 30);

    // en dropped during WAIT: pair still completes
    p0 = npairs;
    bus.en = 1'b1;
    for (int i = 0; i < 20 && npairs == p0; i++) tick();
    bus.en = 1'b0;
    x0 = xfer_cnt;
    check_val("enoff_started", npairs, p0 + 1);
    wait_idle("enoff_idle", 30);
    check_val("enoff_samples", xfer_cnt - x0, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("enoff_stay_idle", {bus.urng_req, bus.busy}, 2'b00);
    end

    // reset held 3 cycles in the middle of EMIT0
    force_rdy_off = 1'b1;
    bus.en = 1'b1;
    wait_valid("rst_valid_seen", 40);
    rst_n = 1'b0;
    bus.en = 1'b0;
    repeat (3) tick();
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    force_rdy_off = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    // 100 pairs with random stalls on both sides
    uv_pct  = 70;
    rdy_pct = 60;
    bus.en  = 1'b1;
    for (int i = 0; i < 20000 && npairs < 100; i++) tick();
    bus.en = 1'b0;
    check_val("bulk_pairs", npairs, 100);
    wait_idle("bulk_idle", 400);
    check_val("bulk_xfers", xfer_cnt, 200);
    check_val("bulk_count", bus.sample_count, exp_final);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
